// File: rtl/tsm_pkg.sv
// tsm_pkg: shared widths, default GF(2) compression matrix and map function
package tsm_pkg;
    localparam int TSM_TERMS = 15;
    localparam int TSM_OUT_W = 4;
    typedef logic [TSM_TERMS-1:0] term_t;
    typedef logic [TSM_OUT_W-1:0] share_t;
    typedef logic [TSM_OUT_W-1:0][TSM_TERMS-1:0] lin_map_t;
    // row j selects the term bits XORed into output bit j
    localparam lin_map_t TSM_LIN_MAP = {15'h7156, 15'h4C9D, 15'h2A6B, 15'h1F35};
    function automatic share_t tsm_map(input term_t x, input lin_map_t m);
        share_t y;
        for (int j = 0; j < TSM_OUT_W; j++) y[j] = ^(x & m[j]);
        return y;
    endfunction
endpackage

// File: rtl/tsm_recombine_if.sv
// tsm_recombine_if: input share beat and output share beat valid/ready bundle
interface tsm_recombine_if import tsm_pkg::*;;
    logic   in_valid, in_ready, out_valid, out_ready;
    term_t  F0, F1;
    share_t PRNG, out_share0, out_share1;
    modport slave(input in_valid, F0, F1, PRNG, out_ready, output in_ready, out_valid, out_share0, out_share1);
    modport master(output in_valid, F0, F1, PRNG, out_ready, input in_ready, out_valid, out_share0, out_share1);
endinterface

// File: rtl/tsm_lin_compress.sv
// tsm_lin_compress: combinational GF(2) TERMS->OUT_W compression of one share
module tsm_lin_compress import tsm_pkg::*; #(
    parameter lin_map_t LIN_MAP = TSM_LIN_MAP
) (
    input  term_t  x,
    output share_t y
);
    always_comb y = tsm_map(x, LIN_MAP);
endmodule

// File: rtl/tsm_recombine.sv
// tsm_recombine: two-stage share compression and common-mask refresh over valid/ready
module tsm_recombine import tsm_pkg::*; #(
    parameter lin_map_t LIN_MAP = TSM_LIN_MAP
) (
    input logic clk,
    input logic rst,
    tsm_recombine_if.slave bus
);
    logic   va, vb, rdy_a, rdy_b;
    term_t  f0_a, f1_a;
    share_t r_a, m0, m1, s0_b, s1_b;
    // one compressor per share, fed only from that share's stage-A register
    tsm_lin_compress #(.LIN_MAP(LIN_MAP)) u_c0 (.x(f0_a), .y(m0));
    tsm_lin_compress #(.LIN_MAP(LIN_MAP)) u_c1 (.x(f1_a), .y(m1));
    always_comb begin
        rdy_b = !vb || bus.out_ready;
        rdy_a = !va || rdy_b;
    end
    assign bus.in_ready   = rdy_a && !rst;
    assign bus.out_valid  = vb;
    assign bus.out_share0 = s0_b;
    assign bus.out_share1 = s1_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            va   <= 1'b0;
            vb   <= 1'b0;
            f0_a <= '0;
            f1_a <= '0;
            r_a  <= '0;
            s0_b <= '0;
            s1_b <= '0;
        end else begin
            if (rdy_a) begin
                va <= bus.in_valid;
                if (bus.in_valid) begin
                    f0_a <= bus.F0;
                    f1_a <= bus.F1;
                    r_a  <= bus.PRNG;
                end
            end
            if (rdy_b) begin
                vb <= va;
                if (va) begin
                    s0_b <= m0 ^ r_a;
                    s1_b <= m1 ^ r_a;
                end
            end
        end
    end
endmodule

// File: tb/tb_tsm_recombine.sv
// tb_tsm_recombine: random and directed scoreboard bench for tsm_recombine
module tb_tsm_recombine;
    import tsm_pkg::*;
    typedef struct {share_t s0; share_t s1; share_t u;} exp_t;
    logic clk = 1'b0, rst = 1'b1;
    int vec = 0, errs = 0;
    exp_t q[$];
    tsm_recombine_if b();
    tsm_recombine dut (.clk(clk), .rst(rst), .bus(b));
    always #5 clk = ~clk;

    // sum of matrix columns selected by the set term bits (linearity view of the map)
    function automatic share_t model(input term_t x);
        lin_map_t m = TSM_LIN_MAP;
        share_t r = '0;
        for (int i = 0; i < TSM_TERMS; i++)
            if (x[i]) for (int j = 0; j < TSM_OUT_W; j++) r[j] = r[j] ^ m[j][i];
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic beat(input term_t f0, input term_t f1, input share_t r, input logic v,
                        input logic ordy, output logic acc, output logic ov);
        @(negedge clk);
        b.in_valid = v; b.F0 = f0; b.F1 = f1; b.PRNG = r; b.out_ready = ordy;
        #1;
        acc = v && b.in_ready;
        ov = b.out_valid;
        if (acc) q.push_back('{model(f0) ^ r, model(f1) ^ r, model(f0 ^ f1)});
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && b.out_valid && b.out_ready) begin
            if (q.size() == 0) chk("extra_beat", 1, 0);
            else begin
                e = q.pop_front();
                chk("sb_share0", b.out_share0, e.s0);
                chk("sb_share1", b.out_share1, e.s1);
                chk("sb_unmask", b.out_share0 ^ b.out_share1, e.u);
            end
        end
    end

    initial begin
        logic acc, ov;
        logic [5:0] pat;
        logic [4:0] apat;
        term_t fa [3];
        int idx;
        b.in_valid = 0; b.F0 = '0; b.F1 = '0; b.PRNG = '0; b.out_ready = 1;
        @(negedge clk); #1;
        chk("rst_in_ready", b.in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_share0", b.out_share0, 0);
        chk("rst_share1", b.out_share1, 0);
        rst = 0;
        beat(15'h0001, '0, '0, 1, 1, acc, ov);
        chk("t1_acc", acc, 1);
        beat('0, '0, '0, 0, 1, acc, ov);
        chk("t1_lat1", ov, 0);
        beat('0, '0, '0, 0, 1, acc, ov);
        chk("t1_lat2", ov, 1);
        chk("t1_col0", b.out_share0, model(15'h0001));
        chk("t1_s1", b.out_share1, 0);
        beat(15'h5A5A, 15'h5A5A, 4'h9, 1, 1, acc, ov);
        beat('0, '0, '0, 0, 1, acc, ov);
        beat('0, '0, '0, 0, 1, acc, ov);
        chk("t2_s0", b.out_share0, model(15'h5A5A) ^ 4'h9);
        chk("t2_s1", b.out_share1, model(15'h5A5A) ^ 4'h9);
        for (int k = 0; k < 6; k++) begin
            beat(15'($urandom), 15'($urandom), 4'($urandom), k < 3, 1, acc, ov);
            pat[5-k] = ov;
        end
        chk("t3_valid_pattern", pat, 6'b001110);
        for (int k = 0; k < 3; k++) fa[k] = 15'($urandom);
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            beat(fa[idx], ~fa[idx], 4'(k), 1, 0, acc, ov);
            apat[4-k] = acc;
            if (acc) idx++;
        end
        chk("t4_accept_pattern", apat, 5'b11000);
        chk("t4_in_ready", b.in_ready, 0);
        chk("t4_hold_s0", b.out_share0, q[0].s0);
        chk("t4_hold_s1", b.out_share1, q[0].s1);
        for (int k = 0; k < 10; k++) begin
            beat(fa[idx > 2 ? 2 : idx], ~fa[idx > 2 ? 2 : idx], 4'hC, idx < 3, 1, acc, ov);
            if (acc) idx++;
        end
        chk("t4_all_accepted", idx, 3);
        chk("t4_drained", q.size(), 0);
        beat(15'h1234, 15'h4321, 4'h3, 1, 0, acc, ov);
        beat(15'h7777, 15'h0F0F, 4'h5, 1, 0, acc, ov);
        @(negedge clk);
        rst = 1; b.in_valid = 0; q.delete();
        @(negedge clk); #1;
        chk("t5_out_valid", b.out_valid, 0);
        chk("t5_share0", b.out_share0, 0);
        chk("t5_share1", b.out_share1, 0);
        chk("t5_in_ready", b.in_ready, 0);
        rst = 0;
        repeat (5) beat('0, '0, '0, 0, 1, acc, ov);
        chk("t5_no_stale", ov, 0);
        for (int k = 0; k < 10000; k++)
            beat(15'($urandom), 15'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, acc, ov);
        repeat (10) beat('0, '0, '0, 0, 1, acc, ov);
        chk("t6_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
